icx_frame_sequencer: RTL and testbench
======================================

Name: icx_frame_sequencer

Overview:
- Top-level frame controller for the ICX CCD path.
- On a start request it sequences one full frame: substrate clear, timed exposure, sensor-gate transfer, then line-by-line vertical shift and horizontal readout.
- It sits between the command/control logic and the CCD timing pins/ADC capture enable.
- It owns the only schedule of the sensor, so start requests arriving while a frame is in progress are ignored.

Parameters:
- LINES, 4, lines read per frame (>=1).
- PIXELS, 8, horizontal pixel clocks per line (>=1).
- CLEAR_PULSES, 2, substrate clear pulses before exposure (>=1).
- SUB_WIDTH, 3, cycles high and cycles low of each substrate pulse (>=1).
- XSG_WIDTH, 2, cycles of the sensor-gate transfer pulse (>=1).
- VSHIFT_WIDTH, 2, cycles of each vertical shift pulse (>=1).
- EXP_W, 16, width of the exposure-time input.
- LINE_W, 8, width of the line index output.
- PIX_W, 8, width of the pixel index output.

Ports:
- clock_in  in  1  system clock; all logic on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- start_i  in  1  frame request; sampled only in IDLE.
- exp_time_i  in  EXP_W  exposure length in clock cycles; latched with start_i.
- abort_i  in  1  abort request; used only with ICX_SEQ_ABORT_EN.
- busy_o  out  1  high in every state other than IDLE.
- sub_o  out  1  substrate clear pulse.
- xsg_o  out  1  sensor-gate transfer pulse.
- v_o  out  1  vertical shift pulse.
- h_en_o  out  1  horizontal clock / ADC capture enable.
- line_o  out  LINE_W  current line index, 0..LINES-1.
- pix_o  out  PIX_W  current pixel index, 0..PIXELS-1; valid while h_en_o=1.
- done_o  out  1  one-cycle frame-complete strobe.

Behaviour:
- Output registration: all outputs registered and decoded from state/counters; no combinational path from inputs to outputs.
- Reset: reset_in=1 at an edge forces IDLE on that edge, including mid-frame. All outputs and counters go to 0; the latched exposure goes to 0.
- State machine: IDLE -> CLEAR -> EXPOSE -> XFER -> VSHIFT -> HREAD -> (VSHIFT | DONE) -> IDLE.
- IDLE:
  - Outputs 0.
  - start_i=1 at edge T latches exp_time_i and enters CLEAR. First CLEAR cycle is T+1, with busy_o=1 and sub_o=1 from T+1.
- CLEAR:
  - CLEAR_PULSES repetitions of SUB_WIDTH cycles with sub_o=1 followed by SUB_WIDTH cycles with sub_o=0.
  - Duration 2*SUB_WIDTH*CLEAR_PULSES cycles.
- EXPOSE:
  - All pulses low for max(exp,1) cycles; exp=0 is treated as 1.
  - Counter is full EXP_W width, with no wrap: the maximum value gives exactly 2^EXP_W-1 cycles.
- XFER: xsg_o=1 for XSG_WIDTH cycles. line_o=0.
- VSHIFT: v_o=1 for VSHIFT_WIDTH cycles.
- HREAD:
  - h_en_o=1 for PIXELS cycles; pix_o counts 0..PIXELS-1, one per cycle.
  - On the last pixel: if line_o==LINES-1 go to DONE, otherwise increment line_o and go to VSHIFT.
  - No idle gap between lines.
- DONE:
  - One cycle with done_o=1 and busy_o=1, then IDLE.
  - line_o and pix_o return to 0 in IDLE.
- Frame length: N = 2*SUB_WIDTH*CLEAR_PULSES + max(exp,1) + XSG_WIDTH + LINES*(VSHIFT_WIDTH+PIXELS).
  - done_o at cycle T+N+1.
  - busy_o high from T+1 through T+N+1.
- Pulse exclusivity: sub_o, xsg_o, v_o and h_en_o are never high simultaneously.
- Inputs while busy: start_i is ignored in any non-IDLE state, including DONE. exp_time_i changes while busy have no effect.
- Back-to-back frames: start_i held high continuously starts a new frame at the first IDLE cycle after DONE.
- Reset vs. start: reset_in and start_i high together resolve to reset.

Optional Feature:
- ICX_SEQ_ABORT_EN defined:
  - abort_i=1 at an edge in any non-IDLE state except DONE enters IDLE on that edge.
  - All pulse outputs and counters cleared; no done_o for the aborted frame.
  - Abort has priority over start_i but not over reset_in.
- Not defined: abort_i is present but ignored, and frames always run to completion.

Test Plan:
- Nominal frame: default params, start_i pulse at T with exp_time_i=10 -> cycle map:
  - sub_o high at T+1..3 and T+7..9.
  - xsg_o at T+23..24.
  - v_o at T+25..26.
  - h_en_o at T+27..34 with pix_o 0..7.
  - 4 lines total; done_o=1 only at T+65; busy_o low at T+66.
- Zero exposure: exp_time_i=0 -> EXPOSE lasts 1 cycle, xsg_o at T+14..15, done_o at T+56.
- Start ignored while busy: start_i pulses at T+5 and T+40 during a frame -> exactly one done_o; the new frame begins only after a start in IDLE.
- Mid-frame reset: reset_in=1 for one edge during line 2 of HREAD -> next cycle all outputs 0 and busy_o=0; a following start gives a full-length frame.
- Abort (macro defined): abort_i at T+30 -> busy_o=0 and h_en_o=0 from T+31, no done_o. Macro undefined: same stimulus -> done_o at T+65.
- Back-to-back: start_i held high -> second frame's sub_o rises at T+67. The pulse-exclusivity invariant is checked every cycle.

Source files
------------

// File: rtl/icx_frame_sequencer.sv
// Frame sequencer for the ICX CCD path: substrate clear, exposure, sensor-gate transfer, line readout.
// Optional abort support is enabled by defining ICX_SEQ_ABORT_EN.
module icx_frame_sequencer #(
  parameter int unsigned LINES        = 4,
  parameter int unsigned PIXELS       = 8,
  parameter int unsigned CLEAR_PULSES = 2,
  parameter int unsigned SUB_WIDTH    = 3,
  parameter int unsigned XSG_WIDTH    = 2,
  parameter int unsigned VSHIFT_WIDTH = 2,
  parameter int unsigned EXP_W        = 16,
  parameter int unsigned LINE_W       = 8,
  parameter int unsigned PIX_W        = 8
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              start_i,
  input  logic [EXP_W-1:0]  exp_time_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              sub_o,
  output logic              xsg_o,
  output logic              v_o,
  output logic              h_en_o,
  output logic [LINE_W-1:0] line_o,
  output logic [PIX_W-1:0]  pix_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    StIdle, StClear, StExpose, StXfer, StVshift, StHread, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0]   pulse_q, pulse_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [EXP_W-1:0]   exp_last;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               busy_q, sub_q, xsg_q, v_q, h_en_q, done_q;
  logic               abort_req;

`ifdef ICX_SEQ_ABORT_EN
  assign abort_req = abort_i;
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign abort_req    = 1'b0;
`endif

  // Zero exposure still costs one cycle; the full-scale value never wraps.
  assign exp_last = (exp_q == '0) ? '0 : exp_q - EXP_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    exp_d   = exp_q;
    line_d  = line_q;
    pix_d   = pix_q;
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        pulse_d = '0;
        line_d  = '0;
        pix_d   = '0;
        if (start_i) begin
          exp_d   = exp_time_i;
          state_d = StClear;
        end
      end
      StClear: begin
        if (cnt_q == EXP_W'(2 * SUB_WIDTH - 1)) begin
          cnt_d = '0;
          if (pulse_q == EXP_W'(CLEAR_PULSES - 1)) begin
            pulse_d = '0;
            state_d = StExpose;
          end else begin
            pulse_d = pulse_q + EXP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + EXP_W'(1);
        end
      end
      StExpose: begin
        if (cnt_q == exp_last) begin
          cnt_d   = '0;
          line_d  = '0;
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q + EXP_W'(1);
        end
      end
      StXfer: begin
        if (cnt_q == EXP_W'(XSG_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StVshift;
        end else begin
          cnt_d = cnt_q + EXP_W'(1);
        end
      end
      StVshift: begin
        if (cnt_q == EXP_W'(VSHIFT_WIDTH - 1)) begin
          cnt_d   = '0;
          pix_d   = '0;
          state_d = StHread;
        end else begin
          cnt_d = cnt_q + EXP_W'(1);
        end
      end
      StHread: begin
        if (pix_q == PIX_W'(PIXELS - 1)) begin
          pix_d = '0;
          if (line_q == LINE_W'(LINES - 1)) begin
            state_d = StDone;
          end else begin
            line_d  = line_q + LINE_W'(1);
            state_d = StVshift;
          end
        end else begin
          pix_d = pix_q + PIX_W'(1);
        end
      end
      StDone: begin
        line_d  = '0;
        pix_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_req && state_q != StIdle && state_q != StDone) begin
      state_d = StIdle;
      cnt_d   = '0;
      pulse_d = '0;
      line_d  = '0;
      pix_d   = '0;
    end
  end

  // Pulse outputs are decoded from next-state values so they align with the state register.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= '0;
      exp_q   <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      sub_q   <= 1'b0;
      xsg_q   <= 1'b0;
      v_q     <= 1'b0;
      h_en_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      exp_q   <= exp_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      busy_q  <= (state_d != StIdle);
      sub_q   <= (state_d == StClear) && (cnt_d < EXP_W'(SUB_WIDTH));
      xsg_q   <= (state_d == StXfer);
      v_q     <= (state_d == StVshift);
      h_en_q  <= (state_d == StHread);
      done_q  <= (state_d == StDone);
    end
  end

  assign busy_o = busy_q;
  assign sub_o  = sub_q;
  assign xsg_o  = xsg_q;
  assign v_o    = v_q;
  assign h_en_o = h_en_q;
  assign line_o = line_q;
  assign pix_o  = pix_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_icx_frame_sequencer.sv
// Bench for icx_frame_sequencer: offset-based frame model checked every cycle plus pinned cycle points.
module tb_icx_frame_sequencer;

  localparam int L = 4, P = 8, CP = 2, SW = 3, XW = 2, VW = 2;

  logic        clk, rst, start, abort;
  logic [15:0] exp_time;
  logic        busy_o, sub_o, xsg_o, v_o, h_en_o, done_o;
  logic [7:0]  line_o, pix_o;

  icx_frame_sequencer dut (
    .clock_in  (clk),
    .reset_in  (rst),
    .start_i   (start),
    .exp_time_i(exp_time),
    .abort_i   (abort),
    .busy_o    (busy_o),
    .sub_o     (sub_o),
    .xsg_o     (xsg_o),
    .v_o       (v_o),
    .h_en_o    (h_en_o),
    .line_o    (line_o),
    .pix_o     (pix_o),
    .done_o    (done_o)
  );

  int checks = 0, errors = 0;
  int ecnt = 0, done_seen = 0, t = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, ecnt);
    end
  endtask

  // Expected outputs for offset k (1 = first cycle after the start edge) of a frame.
  function automatic logic [21:0] model_out(input int k, input int e);
    int clr, r, m;
    logic b, s, x, v, h, d;
    int ln, px;
    clr = 2 * SW * CP;
    b = 1; s = 0; x = 0; v = 0; h = 0; d = 0; ln = 0; px = 0;
    if (k <= clr) s = ((k - 1) % (2 * SW)) < SW;
    else if (k <= clr + e) ;
    else if (k <= clr + e + XW) x = 1;
    else begin
      r = k - (clr + e + XW) - 1;
      if (r < L * (VW + P)) begin
        ln = r / (VW + P);
        m  = r % (VW + P);
        if (m < VW) v = 1;
        else begin h = 1; px = m - VW; end
      end else begin
        d = 1; ln = L - 1;
      end
    end
    return {b, s, x, v, h, d, 8'(ln), 8'(px)};
  endfunction

  // Model + per-cycle compare.
  initial begin
    bit act = 0;
    int k = 0, e = 1, n = 0;
    logic [21:0] req;
    forever begin
      @(posedge clk);
      ecnt++;
      if (rst) act = 0;
      else if (act) begin
        if (k == n + 1) act = 0;
`ifdef ICX_SEQ_ABORT_EN
        else if (abort) act = 0;
`endif
        else k++;
      end else if (start) begin
        act = 1;
        k   = 1;
        e   = (exp_time == 0) ? 1 : int'(exp_time);
        n   = 2 * SW * CP + e + XW + L * (VW + P);
      end
      #1;
      req = act ? model_out(k, e) : 22'd0;
      chk("cycle_model", {busy_o, sub_o, xsg_o, v_o, h_en_o, done_o, line_o, pix_o}, req);
      chk("exclusive", 64'((32'(sub_o) + 32'(xsg_o) + 32'(v_o) + 32'(h_en_o)) > 1), 0);
      if (done_o) done_seen++;
    end
  end

  task automatic at(input int m);
    while (ecnt < t + m - 1) @(negedge clk);
  endtask

  task automatic start_frame(input int e);
    @(negedge clk);
    exp_time = 16'(e);
    start = 1;
    t = ecnt + 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int d0;
    rst = 1; start = 0; abort = 0; exp_time = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_outs", {sub_o, xsg_o, v_o, h_en_o, done_o, line_o, pix_o}, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Nominal frame, with ignored starts and an exposure change mid-frame.
    d0 = done_seen;
    start_frame(10);
    at(1);  chk("nom_sub_t1", sub_o, 1); chk("nom_busy_t1", busy_o, 1);
    at(4);  chk("nom_sub_t4", sub_o, 0);
    at(5);  start = 1; exp_time = 16'd99; @(negedge clk); start = 0;
    at(7);  chk("nom_sub_t7", sub_o, 1);
    at(22); chk("nom_xsg_t22", xsg_o, 0);
    at(23); chk("nom_xsg_t23", xsg_o, 1);
    at(25); chk("nom_v_t25", v_o, 1);
    at(27); chk("nom_h_t27", {h_en_o, pix_o}, {1'b1, 8'd0});
    at(34); chk("nom_h_t34", {h_en_o, pix_o}, {1'b1, 8'd7});
    at(37); chk("nom_line1", line_o, 1);
    at(40); start = 1; @(negedge clk); start = 0;
    at(64); chk("nom_done_t64", done_o, 0);
    at(65); chk("nom_done_t65", done_o, 1);
    at(66); chk("nom_busy_t66", busy_o, 0);
    repeat (3) @(negedge clk);
    chk("nom_one_done", done_seen - d0, 1);
    chk("nom_stays_idle", busy_o, 0);

    // Zero exposure.
    start_frame(0);
    at(13); chk("zero_xsg_t13", xsg_o, 0);
    at(14); chk("zero_xsg_t14", xsg_o, 1);
    at(56); chk("zero_done_t56", done_o, 1);
    repeat (2) @(negedge clk);

    // Mid-frame reset during line 2 readout, together with start.
    start_frame(5);
    at(43); chk("rst_line2", {h_en_o, line_o}, {1'b1, 8'd2});
    rst = 1; start = 1; @(negedge clk); rst = 0; start = 0;
    chk("rst_busy", busy_o, 0);
    chk("rst_outs", {sub_o, xsg_o, v_o, h_en_o, done_o, line_o, pix_o}, 0);
    @(negedge clk);
    chk("rst_no_start", busy_o, 0);
    start_frame(3);
    at(57); chk("rst_full_t57", done_o, 0);
    at(58); chk("rst_full_t58", done_o, 1);
    repeat (2) @(negedge clk);

    // Abort at T+30.
    d0 = done_seen;
    start_frame(10);
    at(30); abort = 1; @(negedge clk); abort = 0;
`ifdef ICX_SEQ_ABORT_EN
    at(31); chk("abort_busy", {busy_o, h_en_o}, 0);
    at(65); chk("abort_no_done", done_seen - d0, 0);
`else
    at(31); chk("noabort_busy", busy_o, 1);
    at(65); chk("noabort_done", done_o, 1);
`endif
    repeat (3) @(negedge clk);

    // Back-to-back with start held high.
    @(negedge clk);
    exp_time = 16'd10; start = 1; t = ecnt + 1;
    at(65); chk("b2b_done1", done_o, 1);
    at(66); chk("b2b_gap", {busy_o, sub_o}, 0);
    at(67); chk("b2b_restart", {busy_o, sub_o}, 2'b11);
    start = 0;
    at(131); chk("b2b_done2", done_o, 1);
    at(132); chk("b2b_idle", busy_o, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
